// File: rtl/reaction_pkg.sv
// Shared encodings for the reaction-time arbiter: FSM state codes, LFSR taps
// and the player-index width helper.
package reaction_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_AVG  = 3'd4,
    ST_CMP  = 3'd5
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int pw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left every clock, feedback enters bit 0.
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] o_lfsr
);
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = ^(r_lfsr & LFSR_TAPS);
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end
endmodule

// File: rtl/reaction_arbiter_core.sv
// Reaction-time test engine: ms timebase, random pre-delay, measurement,
// false-start/timeout handling, per-player accumulation, averaging and winner pick.
module reaction_arbiter_core
  import reaction_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter int          ROUNDS_LOG2 = 3,
  parameter int          TIME_W      = 10,
  parameter int          TIMEOUT     = 999,
  parameter int          DELAY_MIN   = 1000,
  parameter int          DELAY_MAX   = 9999,
  parameter int          TICK_DIV    = 12000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           react,
  input  logic                           avg_req,
  input  logic                           cmp_req,
  input  logic                           abort,
  input  logic [pw_of(NUM_PLAYERS)-1:0]  player_sel,
  output logic [2:0]                     state,
  output logic [pw_of(NUM_PLAYERS)-1:0]  cur_player,
  output logic [ROUNDS_LOG2-1:0]         round_idx,
  output logic [TIME_W-1:0]              disp_value,
  output logic                           result_valid,
  output logic                           foul,
  output logic                           timed_out,
  output logic [NUM_PLAYERS-1:0]         done_mask,
  output logic [pw_of(NUM_PLAYERS)-1:0]  winner,
  output logic                           tie
);
  localparam int PW     = pw_of(NUM_PLAYERS);
  localparam int SUM_W  = TIME_W + ROUNDS_LOG2;
  localparam int RND_W  = ROUNDS_LOG2 + 1;
  localparam int MS_MAX = (DELAY_MAX > TIMEOUT) ? DELAY_MAX : TIMEOUT;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DRANGE = DELAY_MAX - DELAY_MIN + 1;
  localparam int NM_W   = $clog2(NUM_PLAYERS + 1);

  localparam logic [MS_W-1:0]   MS_TO      = MS_W'(TIMEOUT);
  localparam logic [MS_W-1:0]   MS_TO_LAST = MS_W'(TIMEOUT - 1);
  localparam logic [TIME_W-1:0] TO_VAL     = TIME_W'(TIMEOUT);
  localparam logic [PS_W-1:0]   PS_LAST    = PS_W'(TICK_DIV - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         w_lfsr;
  logic [PS_W-1:0]     r_presc;
  logic [MS_W-1:0]     r_ms;
  logic [MS_W-1:0]     r_delay;
  logic                w_tick;
  logic [PW-1:0]       r_cur;
  logic [SUM_W-1:0]    r_sum    [NUM_PLAYERS];
  logic [RND_W-1:0]    r_rounds [NUM_PLAYERS];
  logic [TIME_W-1:0]   r_last;
  logic                r_rv;
  logic                r_foul;
  logic                r_to;
  logic                w_wait_entry;
  logic                w_run_entry;
  logic                w_rec;
  logic                w_rec_foul;
  logic                w_rec_to;
  logic [TIME_W-1:0]   w_rec_val;
  logic [NUM_PLAYERS-1:0] w_done;
  logic                w_cur_done;
  logic                w_sel_done;
  logic [SUM_W-1:0]    w_min;
  logic [PW-1:0]       w_win;
  logic [NM_W-1:0]     w_nmin;
  logic [TIME_W-1:0]   w_live_ms;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .o_lfsr (w_lfsr)
  );

  assign w_tick = (r_presc == PS_LAST);

  always_comb begin
    w_done = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_done[p] = r_rounds[p][ROUNDS_LOG2];
    end
  end

  assign w_cur_done = w_done[r_cur];
  assign w_sel_done = w_done[player_sel];

  // abort dominates; within a state the request order is react > cmp_req > avg_req > start
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_entry = 1'b0;
    w_run_entry  = 1'b0;
    w_rec        = 1'b0;
    w_rec_foul   = 1'b0;
    w_rec_to     = 1'b0;
    w_rec_val    = '0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt  = ST_WAIT;
            w_wait_entry = 1'b1;
          end
        end
        ST_WAIT: begin
          if (react) begin
            w_state_nxt = ST_HOLD;
            w_rec       = 1'b1;
            w_rec_val   = TO_VAL;
            w_rec_foul  = 1'b1;
          end else if (w_tick && (r_ms == r_delay - MS_W'(1))) begin
            w_state_nxt = ST_RUN;
            w_run_entry = 1'b1;
          end
        end
        ST_RUN: begin
          if (react) begin
            w_state_nxt = ST_HOLD;
            w_rec       = 1'b1;
            w_rec_val   = TIME_W'(r_ms);
          end else if (w_tick && (r_ms == MS_TO_LAST)) begin
            w_state_nxt = ST_HOLD;
            w_rec       = 1'b1;
            w_rec_val   = TO_VAL;
            w_rec_to    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (w_cur_done) begin
            if (avg_req) begin
              w_state_nxt = ST_AVG;
            end
          end else if (start) begin
            w_state_nxt  = ST_WAIT;
            w_wait_entry = 1'b1;
          end
        end
        ST_AVG: begin
          if (cmp_req && (&w_done)) begin
            w_state_nxt = ST_CMP;
          end else if (start && !w_sel_done) begin
            w_state_nxt  = ST_WAIT;
            w_wait_entry = 1'b1;
          end
        end
        ST_CMP: begin
          w_state_nxt = ST_CMP;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_delay <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wait_entry) begin
        r_cur   <= player_sel;
        r_delay <= MS_W'(32'(DELAY_MIN) + (32'(w_lfsr) % 32'(DRANGE)));
      end
    end
  end

  // ms counter parks at all-ones outside a measurement rather than wrapping
  always_ff @(posedge clk) begin
    if (rst || w_wait_entry || w_run_entry) begin
      r_presc <= '0;
      r_ms    <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_ms != '1) begin
        r_ms <= r_ms + MS_W'(1);
      end
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        r_sum[p]    <= '0;
        r_rounds[p] <= '0;
      end
      r_last <= '0;
      r_rv   <= 1'b0;
      r_foul <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_rv <= w_rec;
      if (w_wait_entry) begin
        r_foul <= 1'b0;
        r_to   <= 1'b0;
      end
      if (w_rec) begin
        r_sum[r_cur]    <= r_sum[r_cur] + SUM_W'(w_rec_val);
        r_rounds[r_cur] <= r_rounds[r_cur] + RND_W'(1);
        r_last          <= w_rec_val;
        r_foul          <= w_rec_foul;
        r_to            <= w_rec_to;
      end
    end
  end

  // strict '<' keeps the lowest index among equal minima
  always_comb begin
    w_min  = r_sum[0];
    w_win  = '0;
    w_nmin = '0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (r_sum[p] < w_min) begin
        w_min = r_sum[p];
        w_win = PW'(p);
      end
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (r_sum[p] == w_min) begin
        w_nmin = w_nmin + NM_W'(1);
      end
    end
  end

  assign w_live_ms = (r_ms >= MS_TO) ? TO_VAL : TIME_W'(r_ms);

  always_comb begin
    disp_value = '0;
    case (r_state)
      ST_RUN:  disp_value = w_live_ms;
      ST_HOLD: disp_value = r_last;
      ST_AVG:  disp_value = TIME_W'(r_sum[r_cur] >> ROUNDS_LOG2);
      ST_CMP:  disp_value = TIME_W'(r_sum[w_win] >> ROUNDS_LOG2);
      default: disp_value = '0;
    endcase
  end

  assign state        = r_state;
  assign cur_player   = r_cur;
  assign round_idx    = r_rounds[r_cur][ROUNDS_LOG2-1:0];
  assign result_valid = r_rv;
  assign foul         = r_foul;
  assign timed_out    = r_to;
  assign done_mask    = w_done;
  assign winner       = (r_state == ST_CMP) ? w_win : '0;
  assign tie          = (r_state == ST_CMP) && (w_nmin > NM_W'(1));
endmodule

// File: tb/tb_reaction_arbiter_core.sv
// Directed bench for reaction_arbiter_core with a result scoreboard checked on result_valid.
module tb_reaction_arbiter_core;
  localparam int NP = 2, RL = 1, TW = 10, TO = 20, DMIN = 5, DMAX = 8, TD = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_RUN = 3'd2,
                         S_HOLD = 3'd3, S_AVG = 3'd4, S_CMP = 3'd5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, react = 1'b0, avg_req = 1'b0, cmp_req = 1'b0, abort = 1'b0;
  logic [0:0]    player_sel = 1'b0;
  logic [2:0]    state;
  logic [0:0]    cur_player;
  logic [RL-1:0] round_idx;
  logic [TW-1:0] disp_value;
  logic          result_valid, foul, timed_out, tie;
  logic [NP-1:0] done_mask;
  logic [0:0]    winner;

  typedef struct {
    int   val;
    logic fl;
    logic to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  reaction_arbiter_core #(
    .NUM_PLAYERS(NP), .ROUNDS_LOG2(RL), .TIME_W(TW), .TIMEOUT(TO),
    .DELAY_MIN(DMIN), .DELAY_MAX(DMAX), .TICK_DIV(TD), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .react(react), .avg_req(avg_req),
    .cmp_req(cmp_req), .abort(abort), .player_sel(player_sel), .state(state),
    .cur_player(cur_player), .round_idx(round_idx), .disp_value(disp_value),
    .result_valid(result_valid), .foul(foul), .timed_out(timed_out),
    .done_mask(done_mask), .winner(winner), .tie(tie)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid === 1'b1) begin
      check("sb_nonempty", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("rec_value", disp_value, mon_e.val);
        check("rec_foul", foul, mon_e.fl);
        check("rec_timeout", timed_out, mon_e.to);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic s);
    start = 1'b1; player_sel = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_react();
    react = 1'b1; @(negedge clk); react = 1'b0;
  endtask

  task automatic pulse_avg();
    avg_req = 1'b1; @(negedge clk); avg_req = 1'b0;
  endtask

  task automatic pulse_cmp();
    cmp_req = 1'b1; @(negedge clk); cmp_req = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1; @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cyc);
    cyc = 0;
    while (state !== s && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (state !== s) check("wait_state_bound", state, s);
  endtask

  task automatic play_round(input logic s, input int n);
    int c;
    pulse_start(s);
    check("round_wait", state, S_WAIT);
    wait_state(S_RUN, 64, c);
    tick(n * TD + 1);
    sb.push_back('{n, 1'b0, 1'b0});
    pulse_react();
    check("round_hold", state, S_HOLD);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", state, S_IDLE);
    check("rst_cur", cur_player, 0);
    check("rst_round", round_idx, 0);
    check("rst_disp", disp_value, 0);
    check("rst_rv", result_valid, 0);
    check("rst_foul", foul, 0);
    check("rst_to", timed_out, 0);
    check("rst_done", done_mask, 0);
    check("rst_winner", winner, 0);
    check("rst_tie", tie, 0);
  endtask

  initial begin
    int c, c2, d_first;
    logic [3:0] seen;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // first round: react 7 ms into RUN
    pulse_start(1'b0);
    check("a_wait", state, S_WAIT);
    wait_state(S_RUN, 64, d_first);
    check("a_delay", (d_first % TD == 0) && (d_first / TD >= DMIN) && (d_first / TD <= DMAX), 1);
    tick(7 * TD + 1);
    sb.push_back('{7, 1'b0, 1'b0});
    pulse_react();
    check("a_state", state, S_HOLD);
    check("a_disp", disp_value, 7);
    check("a_round", round_idx, 1);
    check("a_rv", result_valid, 1);
    tick(1);
    check("a_rv_pulse", result_valid, 0);

    // false start finishes player 0 with sum 27
    pulse_start(1'b0);
    check("b_wait", state, S_WAIT);
    tick(3);
    sb.push_back('{TO, 1'b1, 1'b0});
    pulse_react();
    check("b_state", state, S_HOLD);
    check("b_foul", foul, 1);
    check("b_disp", disp_value, TO);
    check("b_done", done_mask, 2'b01);
    check("b_round", round_idx, 0);
    pulse_start(1'b1);
    check("b_start_ignored", state, S_HOLD);
    pulse_avg();
    check("b_avg_state", state, S_AVG);
    check("b_avg_disp", disp_value, 13);
    pulse_start(1'b1);
    check("b_wait2", state, S_WAIT);
    check("b_foul_clr", foul, 0);
    check("b_cur", cur_player, 1);
    check("b_wait_disp", disp_value, 0);

    // player 1 times out, then scores 8
    wait_state(S_RUN, 64, c);
    sb.push_back('{TO, 1'b0, 1'b1});
    tick(41);
    check("c_live_ms", disp_value, 10);
    wait_state(S_HOLD, 100, c);
    check("c_timeout_lat", c + 41, 80);
    check("c_to", timed_out, 1);
    check("c_disp", disp_value, TO);
    play_round(1'b1, 8);
    check("c_done", done_mask, 2'b11);
    pulse_avg();
    check("c_avg", disp_value, 14);
    pulse_cmp();
    check("c_cmp_state", state, S_CMP);
    check("c_winner", winner, 0);
    check("c_tie", tie, 0);
    check("c_cmp_disp", disp_value, 13);
    pulse_start(1'b0);
    check("c_cmp_hold", state, S_CMP);
    pulse_abort();
    check("c_abort_state", state, S_IDLE);
    check("c_abort_done", done_mask, 0);

    // 6,10 vs 8,8 -> tie
    play_round(1'b0, 6);
    play_round(1'b0, 10);
    pulse_avg();
    check("d_avg0", disp_value, 8);
    pulse_cmp();
    check("d_cmp_blocked", state, S_AVG);
    play_round(1'b1, 8);
    play_round(1'b1, 8);
    pulse_avg();
    pulse_cmp();
    check("d_cmp_state", state, S_CMP);
    check("d_winner", winner, 0);
    check("d_tie", tie, 1);
    check("d_disp", disp_value, 8);

    // 6,10 vs 8,9 -> player 0 alone
    pulse_abort();
    play_round(1'b0, 6);
    play_round(1'b0, 10);
    pulse_avg();
    play_round(1'b1, 8);
    play_round(1'b1, 9);
    pulse_avg();
    pulse_cmp();
    check("d2_winner", winner, 0);
    check("d2_tie", tie, 0);
    check("d2_disp", disp_value, 8);

    // 10,10 vs 6,7 -> player 1 wins
    pulse_abort();
    play_round(1'b0, 10);
    play_round(1'b0, 10);
    pulse_avg();
    play_round(1'b1, 6);
    play_round(1'b1, 7);
    pulse_avg();
    check("d3_avg1", disp_value, 6);
    pulse_cmp();
    check("d3_winner", winner, 1);
    check("d3_tie", tie, 0);
    check("d3_disp", disp_value, 6);

    // abort together with react in RUN
    pulse_abort();
    play_round(1'b0, 4);
    check("e_round1", round_idx, 1);
    pulse_start(1'b0);
    wait_state(S_RUN, 64, c);
    tick(10);
    abort = 1'b1; react = 1'b1;
    @(negedge clk);
    abort = 1'b0; react = 1'b0;
    check("e_state", state, S_IDLE);
    check("e_rv", result_valid, 0);
    check("e_done", done_mask, 0);
    check("e_round", round_idx, 0);
    play_round(1'b0, 3);
    play_round(1'b0, 5);
    pulse_avg();
    check("e_sum_cleared", disp_value, 4);

    // delay distribution over 200 WAIT entries
    pulse_abort();
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      pulse_start(1'b0);
      wait_state(S_RUN, 64, c);
      check("f_delay_range", (c % TD == 0) && (c / TD >= DMIN) && (c / TD <= DMAX), 1);
      if ((c % TD == 0) && (c / TD >= DMIN) && (c / TD <= DMAX)) seen[c / TD - DMIN] = 1'b1;
      pulse_abort();
    end
    for (int i = 0; i < 4; i++) check("f_delay_seen", seen[i], 1);

    // reset in the middle of WAIT
    pulse_start(1'b1);
    tick(5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    pulse_start(1'b0);
    wait_state(S_RUN, 64, c2);
    check("g_lfsr_reseed", c2, d_first);
    check("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
